// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: CSR register offsets,
// register bit positions and the interrupt threshold helper.
// Imported by uart_rx_fifo. It has no ports and no logic of its own.
package uart_pkg;

   // Register offsets decoded from csr_a[1:0]
   localparam logic [1:0] UART_RXF_DATA = 2'b00;
   localparam logic [1:0] UART_RXF_STAT = 2'b01;
   localparam logic [1:0] UART_RXF_CTRL = 2'b10;

   // Bit positions inside the STATUS and CTRL words
   localparam int STAT_OVF   = 31;
   localparam int STAT_FULL  = 24;
   localparam int STAT_EMPTY = 23;
   localparam int CTRL_IRQEN = 31;

   // Width of the threshold field and of the count field in STATUS
   localparam int THR_W = 9;

   // A programmed threshold of 0 behaves like 1, so an empty FIFO never
   // raises the interrupt.
   function automatic logic [THR_W-1:0] eff_threshold(input logic [THR_W-1:0] thr);
      return (thr == '0) ? THR_W'(1) : thr;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CSR bus plus UART receive strobe seen by the receive buffer.
// master: CPU/UART side (drives address, write data, rx byte);
// slave: the buffer (returns registered read data and the interrupt).
interface uart_rx_fifo_if;
   logic [13:0] csr_a;    // [13:10] bank, [1:0] register
   logic        csr_we;   // write strobe
   logic [31:0] csr_di;   // write data
   logic [31:0] csr_do;   // registered read data
   logic [7:0]  rx_data;  // byte from UART core, valid with rx_done
   logic        rx_done;  // one-cycle pulse per received byte
   logic        irq;      // level interrupt, registered

   modport master (
      output csr_a, csr_we, csr_di, rx_data, rx_done,
      input  csr_do, irq
   );

   modport slave (
      input  csr_a, csr_we, csr_di, rx_data, rx_done,
      output csr_do, irq
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push, pop, flush and level.
// Latency: a pushed word is visible at head_o the next cycle (async head read).
// Backpressure: none; a push while full without a same-cycle pop is refused
// and flagged on drop_o. A pop while empty is ignored. Flush beats both.
// Ports: clk_i/rst_i (sync, active high), push_i/din_i, pop_i, flush_i,
// head_o, count_o, count_next_o, full_o, empty_o, drop_o.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [$clog2(DEPTH):0]     count_next_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       drop_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   // A pop only counts when there is something to pop; a push is accepted
   // when there is room, or when a real pop frees a slot in the same cycle.
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign drop_o  = push_i & ~push_ok & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o       = mem_q[rd_ptr_q];
   assign count_o      = count_q;
   assign count_next_o = count_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures rx_done bytes into a FIFO drained over a
// 4-word CSR window, with sticky overflow and a level threshold interrupt.
// Latency: csr_do and irq are registered (1 cycle); a byte is readable the
// cycle after rx_done. Backpressure: none toward the UART; bytes arriving
// while full are dropped and flagged.
// Ports: sys_clk, sys_rst (sync, active high), bus (uart_rx_fifo_if.slave).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter logic [3:0] csr_addr = 4'h1,
   parameter int         DEPTH    = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   uart_rx_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   logic             sel, csr_wr;
   logic [1:0]       reg_a;
   logic             pop_req, flush_req, ovf_clr, ctrl_wr;

   logic [7:0]       head;
   logic [AW:0]      count, count_next;
   logic             full, empty, drop;

   logic             ovf_q, ovf_d;
   logic             irq_en_q, irq_en_d;
   logic [THR_W-1:0] thr_q, thr_d;
   logic             irq_q, irq_d;
   logic [31:0]      do_q, do_d;
   logic [31:0]      rdata;

   // Address bits between the bank field and the register field are not decoded
   logic             unused_bits;
   assign unused_bits = ^{bus.csr_a[9:2], bus.csr_di[30:THR_W]};

   assign sel    = (bus.csr_a[13:10] == csr_addr);
   assign reg_a  = bus.csr_a[1:0];
   assign csr_wr = sel & bus.csr_we;

   assign pop_req   = csr_wr && (reg_a == UART_RXF_DATA);
   assign flush_req = csr_wr && (reg_a == UART_RXF_STAT) && bus.csr_di[0];
   assign ovf_clr   = csr_wr && (reg_a == UART_RXF_STAT) && bus.csr_di[STAT_OVF];
   assign ctrl_wr   = csr_wr && (reg_a == UART_RXF_CTRL);

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (sys_clk),
      .rst_i        (sys_rst),
      .push_i       (bus.rx_done),
      .din_i        (bus.rx_data),
      .pop_i        (pop_req),
      .flush_i      (flush_req),
      .head_o       (head),
      .count_o      (count),
      .count_next_o (count_next),
      .full_o       (full),
      .empty_o      (empty),
      .drop_o       (drop)
   );

   // Read mux works on current state, so a DATA read that also pops
   // returns the byte leaving the FIFO.
   always_comb begin
      rdata = '0;
      case (reg_a)
         UART_RXF_DATA: begin
            if (!empty) rdata = {23'b0, 1'b1, head};
         end
         UART_RXF_STAT: begin
            rdata[STAT_OVF]    = ovf_q;
            rdata[STAT_FULL]   = full;
            rdata[STAT_EMPTY]  = empty;
            rdata[THR_W-1:0]   = THR_W'(count);
         end
         UART_RXF_CTRL: begin
            rdata[CTRL_IRQEN]  = irq_en_q;
            rdata[THR_W-1:0]   = thr_q;
         end
         default: rdata = '0;
      endcase
   end

   always_comb begin
      do_d     = sel ? rdata : 32'h0;
      // A drop in the same cycle as a clear leaves the flag set
      ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
      irq_en_d = ctrl_wr ? bus.csr_di[CTRL_IRQEN] : irq_en_q;
      thr_d    = ctrl_wr ? bus.csr_di[THR_W-1:0]  : thr_q;
      // Thresholds above DEPTH can never be met by the count
      irq_d    = irq_en_q & (THR_W'(count_next) >= eff_threshold(thr_q));
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         thr_q    <= THR_W'(1);
         irq_q    <= 1'b0;
         do_q     <= '0;
      end else begin
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         thr_q    <= thr_d;
         irq_q    <= irq_d;
         do_q     <= do_d;
      end
   end

   assign bus.csr_do = do_q;
   assign bus.irq    = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam logic [3:0] BANK  = 4'h1;
   localparam int         DEPTH = 16;

   logic sys_clk = 1'b0;
   logic sys_rst;
   uart_rx_fifo_if bus ();

   uart_rx_fifo #(
      .csr_addr (BANK),
      .DEPTH    (DEPTH)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: a plain byte queue plus the control fields
   logic [7:0] mq[$];
   bit         m_ovf;
   bit         m_en;
   int         m_thr;

   logic [31:0] last_do;
   logic        last_irq;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the same cycle, then
   // compare the registered outputs just after the clock edge.
   task automatic step(input bit rst, input bit sel, input bit we, input bit [1:0] a,
                       input bit [31:0] di, input bit rxd, input bit [7:0] rxb,
                       input string tag);
      logic [31:0] e_do;
      bit          e_irq;
      bit          ovf_set;
      int          thr_eff;
      sys_rst     = rst;
      bus.csr_a   = {(sel ? BANK : (BANK ^ 4'h6)), 8'h00, a};
      bus.csr_we  = we;
      bus.csr_di  = di;
      bus.rx_done = rxd;
      bus.rx_data = rxb;
      e_do    = 32'h0;
      e_irq   = 1'b0;
      ovf_set = 1'b0;
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
         m_en  = 1'b0;
         m_thr = 1;
      end else begin
         if (sel) begin
            case (a)
               2'd0: e_do = (mq.size() > 0) ? {23'b0, 1'b1, mq[0]} : 32'h0;
               2'd1: e_do = {m_ovf, 6'b0, (mq.size() == DEPTH), (mq.size() == 0),
                             14'b0, 9'(mq.size())};
               2'd2: e_do = {m_en, 22'b0, 9'(m_thr)};
               default: e_do = 32'h0;
            endcase
         end
         if (sel && we && a == 2'd1 && di[0]) begin
            mq.delete();
         end else begin
            if (sel && we && a == 2'd0 && mq.size() > 0) void'(mq.pop_front());
            if (rxd) begin
               if (mq.size() < DEPTH) mq.push_back(rxb);
               else ovf_set = 1'b1;
            end
         end
         if (sel && we && a == 2'd1 && di[31]) m_ovf = 1'b0;
         if (ovf_set) m_ovf = 1'b1;
         thr_eff = (m_thr == 0) ? 1 : m_thr;
         e_irq = m_en && (mq.size() >= thr_eff);
         if (sel && we && a == 2'd2) begin
            m_en  = di[31];
            m_thr = int'(di[8:0]);
         end
      end
      @(posedge sys_clk);
      #1;
      last_do  = bus.csr_do;
      last_irq = bus.irq;
      chk({tag, "_do"},  last_do, e_do);
      chk({tag, "_irq"}, {31'b0, last_irq}, {31'b0, e_irq});
   endtask

   task automatic rd(input bit [1:0] a, input string tag);
      step(0, 1, 0, a, 32'h0, 0, 8'h00, tag);
   endtask

   task automatic wr(input bit [1:0] a, input bit [31:0] d, input string tag);
      step(0, 1, 1, a, d, 0, 8'h00, tag);
   endtask

   task automatic push(input bit [7:0] b, input string tag);
      step(0, 0, 0, 2'd0, 32'h0, 1, b, tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and reset-state readback
      step(1, 0, 0, 2'd0, 32'h0, 0, 8'h00, "rst");
      step(1, 0, 0, 2'd0, 32'h0, 0, 8'h00, "rst");
      rd(2'd1, "rst_stat");
      chk("rst_stat_val", last_do, 32'h0080_0000);
      rd(2'd2, "rst_ctrl");
      chk("rst_ctrl_val", last_do, 32'h0000_0001);
      chk("rst_irq_val", {31'b0, last_irq}, 32'h0);

      // Basic push / read / pop
      push(8'h41, "p41");
      push(8'h42, "p42");
      push(8'h43, "p43");
      rd(2'd0, "rd41");
      chk("rd41_val", last_do, 32'h0000_0141);
      wr(2'd0, 32'h0, "pop41");
      rd(2'd0, "rd42");
      chk("rd42_val", last_do, 32'h0000_0142);
      rd(2'd1, "stat2");
      chk("stat2_val", last_do, 32'h0000_0002);

      // Overflow: 17 bytes into an empty FIFO
      wr(2'd1, 32'h0000_0001, "flush1");
      for (int i = 0; i < 17; i++) push(8'(i), "ovfpush");
      rd(2'd1, "ovfstat");
      chk("ovfstat_val", last_do, 32'h8100_0010);
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 1, 2'd0, 32'h0, 0, 8'h00, "drain");
         chk("drain_val", last_do, 32'h100 | 32'(i));
      end
      wr(2'd1, 32'h8000_0000, "ovfclr");
      rd(2'd1, "ovfclr_stat");
      chk("ovfclr_val", last_do, 32'h0080_0000);

      // Push and pop together while full
      for (int i = 0; i < 16; i++) push(8'(i), "fill");
      step(0, 1, 1, 2'd0, 32'h0, 1, 8'hAA, "fullpp");
      rd(2'd1, "fullpp_stat");
      chk("fullpp_val", last_do, 32'h0100_0010);
      for (int i = 0; i < 16; i++) step(0, 1, 1, 2'd0, 32'h0, 0, 8'h00, "drain2");
      chk("last_aa", last_do, 32'h0000_01AA);

      // Threshold interrupt
      wr(2'd2, 32'h8000_0004, "ctrl4");
      push(8'h01, "t1");
      push(8'h02, "t2");
      push(8'h03, "t3");
      chk("thr_below", {31'b0, last_irq}, 32'h0);
      push(8'h04, "t4");
      chk("thr_hit", {31'b0, last_irq}, 32'h1);
      wr(2'd0, 32'h0, "tpop");
      chk("thr_drop", {31'b0, last_irq}, 32'h0);
      wr(2'd1, 32'h0000_0001, "flush2");
      push(8'h77, "t0push");
      wr(2'd2, 32'h8000_0000, "ctrl0");
      step(0, 0, 0, 2'd0, 32'h0, 0, 8'h00, "t0idle");
      chk("thr0_irq", {31'b0, last_irq}, 32'h1);

      // Flush against a same-cycle push
      wr(2'd1, 32'h0000_0001, "flush3");
      for (int i = 0; i < 5; i++) push(8'(8'h30 + i), "f5");
      step(0, 1, 1, 2'd1, 32'h0000_0001, 1, 8'h55, "flushpush");
      rd(2'd1, "flushpush_stat");
      chk("flushpush_val", last_do, 32'h0080_0000);

      // Reset in the middle of traffic
      wr(2'd2, 32'h8000_0002, "ctrl2");
      for (int i = 0; i < 18; i++) push(8'(i), "pre_rst");
      step(1, 1, 1, 2'd1, 32'h0, 1, 8'h99, "midrst");
      chk("midrst_do", last_do, 32'h0);
      chk("midrst_irq", {31'b0, last_irq}, 32'h0);
      rd(2'd1, "post_stat");
      chk("post_stat_val", last_do, 32'h0080_0000);
      rd(2'd2, "post_ctrl");
      chk("post_ctrl_val", last_do, 32'h0000_0001);

      // Randomized traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         bit        r_rst, r_sel, r_we, r_rxd;
         bit [1:0]  r_a;
         bit [31:0] r_di;
         int        push_pct;
         push_pct = ((i / 200) % 2 == 0) ? 60 : 10;
         r_rst = ($urandom_range(0, 199) == 0);
         r_sel = ($urandom_range(0, 9) < 7);
         r_we  = $urandom_range(0, 1) == 1;
         r_a   = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom_range(0, 3));
         r_di  = $urandom;
         if (r_a == 2'd1) r_di[0] = ($urandom_range(0, 15) == 0);
         if (r_a == 2'd2) r_di[8:0] = 9'($urandom_range(0, 20));
         r_rxd = ($urandom_range(0, 99) < push_pct);
         step(r_rst, r_sel, r_we, r_a, r_di, r_rxd, 8'($urandom), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART core. It captures each byte presented with the UART's rx_done pulse into a DEPTH-entry FIFO, so software is not forced to service every byte before the next one arrives. Software drains and controls the buffer through its own 4-word CSR window on the shared CSR bus. A level interrupt asserts when the fill level reaches a programmable threshold.

Parameters:
csr_addr, 4'h1, CSR bank select; compared against csr_a[13:10]
DEPTH, 16, FIFO entries; power of two, 2..256
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
csr_a  in  14  CSR address; [13:10] bank, [1:0] register
csr_we  in  1  CSR write strobe
csr_di  in  32  CSR write data
csr_do  out  32  CSR read data, registered
rx_data  in  8  received byte from UART core; valid when rx_done=1
rx_done  in  1  one-cycle pulse per received byte (UART rx_irq)
irq  out  1  level interrupt, registered

Behaviour:
- One clock; reset is synchronous and active-high (sys_clk, sys_rst).
- Reset: rd_ptr=wr_ptr=0, count=0, overflow=0, irq_en=0, threshold=1, csr_do=0, irq=0. FIFO storage is not cleared.
- Register map, csr_a[1:0]:
  - 00 DATA. Read: {23'b0, valid, head_byte}; valid=!empty. When empty, head_byte=0. Write (any value): pop one entry.
  - 01 STATUS. Read: {overflow[31], 6'b0, full[24], empty[23], 14'b0, count[8:0]}. Write: csr_di[31]=1 clears overflow; csr_di[0]=1 flushes the FIFO (pointers and count set to 0).
  - 10 CTRL. Read/write: {irq_en[31], 22'b0, threshold[8:0]}.
  - 11: reads 0; writes ignored.
- csr_do: 1-cycle registered. Value = register contents sampled in the access cycle. csr_do=0 in any cycle the bank is not selected.
- DATA read with a same-cycle DATA write returns the byte being popped.
- Push: rx_done=1 and not full -> store rx_data at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1.
- Full push: rx_done=1 while full and no same-cycle pop -> byte dropped, overflow set (sticky), FIFO unchanged.
- Simultaneous push and pop:
  - both take effect; count unchanged; no overflow, even when full.
  - when empty: push takes effect, pop ignored (count becomes 1).
- Pop while empty: ignored; no flag; pointers and count unchanged.
- Flush:
  - takes priority over any same-cycle push or pop; that push is lost and overflow is not set.
  - an overflow-clear and a flush in the same write both take effect.
- Overflow set vs. clear in the same cycle: set wins.
- threshold: 0 is treated as 1. A value above DEPTH means the count condition never asserts.
- irq <= irq_en & (count_next >= eff_threshold). Asserts the cycle after the push that reaches the threshold. Deasserts the cycle after the pop/flush that drops count below it.
- count is AW+1 bits: 0..DEPTH. full = (count==DEPTH), empty = (count==0).
- Storage: register array or inferred RAM with asynchronous read of the head. No bypass latency: a byte pushed in cycle N is readable at DATA in cycle N+1.

Decomposition:
- Package uart_pkg:
  - register offset constants: UART_RXF_DATA=2'b00, UART_RXF_STAT=2'b01, UART_RXF_CTRL=2'b10
  - bit-position constants: STAT_OVF=31, STAT_FULL=24, STAT_EMPTY=23, CTRL_IRQEN=31
- One sub-module: uart_sync_fifo. Generic DEPTH x WIDTH synchronous FIFO with push/pop/flush, count, full, empty, head data.
- uart_rx_fifo holds the CSR decode, the overflow and threshold logic, and the irq register.

Test Plan:
- Reset, then read STATUS -> csr_do=0x00800000 (empty=1, count=0). Read CTRL -> 0x00000001. irq=0.
- Push 0x41, 0x42, 0x43 via rx_done pulses. Read DATA -> 0x141. Write DATA, read DATA -> 0x142. STATUS count=2.
- Push 17 bytes 0x00..0x10 into empty FIFO (DEPTH=16) -> STATUS=0x81000010 (overflow, full, count=16). Drain 16 pops -> bytes 0x00..0x0F in order, 0x10 lost. Write STAT 0x80000000 -> overflow cleared.
- While full, pulse rx_done=0xAA in the same cycle as a DATA write -> count stays 16, overflow stays 0. Last entry read after draining = 0xAA.
- CTRL=0x80000004. Push 3 bytes -> irq=0. Push 4th -> irq=1 the next cycle. One pop -> irq=0 the next cycle. CTRL threshold=0 with 1 entry -> irq=1.
- With 5 entries, write STAT 0x00000001 in the same cycle as rx_done -> count=0, empty=1, overflow=0. Assert sys_rst mid-stream -> all state back to reset values the next cycle.
